otter_mem_arbiter: RTL and testbench
====================================

Name: otter_mem_arbiter

Overview:
Shares one memory port between the instruction-fetch requester and the load/store requester of the multicycle OTTER. It arbitrates, issues one command at a time to the memory, counts out the fixed read latency and returns completion strobes with held read data. Data accesses have priority, and a starvation counter guarantees fetch progress. It sits between the CU FSM/datapath and a single-ported memory wrapper.

Parameters:
MEM_LAT, 1, cycles from M_RD issue to M_RDATA valid (legal 1..4)
STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced to win (legal 1..15)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
F_REQ  in  1  fetch request, held until F_DONE
F_ADDR  in  32  fetch byte address
F_DONE  out  1  one-cycle fetch completion pulse
F_RDATA  out  32  fetched word, held until next F_DONE
D_REQ  in  1  data request, held until D_DONE
D_WE  in  1  1 = store, 0 = load
D_ADDR  in  32  data byte address
D_WDATA  in  32  store data
D_SIZE  in  2  access size, passed through
D_SIGN  in  1  load sign control, passed through
D_DONE  out  1  one-cycle data completion pulse
D_RDATA  out  32  load data, held until next load D_DONE
M_ADDR  out  32  memory address
M_WDATA  out  32  memory write data
M_RD  out  1  read strobe, one cycle per read
M_WR  out  1  write strobe, one cycle per store
M_SIZE  out  2  size to memory (2'b10 for fetch)
M_SIGN  out  1  sign to memory (0 for fetch)
M_RDATA  in  32  memory read data
BUSY  out  1  transaction outstanding

Behaviour:
- Reset (async, RESET=1): state IDLE; all outputs 0; F_RDATA and D_RDATA hold registers 0; starve counter 0. A transaction in flight is dropped with no DONE.
- States: IDLE, WAIT_F, WAIT_D. BUSY=1 in WAIT_*.
- Issue cycle: the arbiter issues in IDLE or in a DONE cycle. M_ADDR, M_WDATA, M_SIZE, M_SIGN and the M_RD/M_WR strobe are driven combinationally from the winner's inputs in that cycle only. Outside issue cycles, strobes are 0 and the other M_* outputs are 0.
- Arbitration: if only one port requests, it wins. If both request, D wins unless starve==STARVE_LIMIT, in which case F wins.
- Starve counter: increments, saturating at STARVE_LIMIT, when D wins while F_REQ=1. Clears when F wins. Unchanged otherwise.
- Read issued at cycle t: DONE is asserted in cycle t+MEM_LAT, with *_RDATA = M_RDATA combinationally in that cycle. The value is also registered so *_RDATA holds afterwards.
- Store issued at cycle t: M_WR=1 in cycle t; D_DONE in cycle t+1 regardless of MEM_LAT; D_RDATA unchanged.
- Latency counter: loaded with MEM_LAT (read) or 1 (store) at issue; decrements each cycle in WAIT_*; DONE when it reaches 0 on the following cycle.
- DONE cycle: the completing port's REQ is masked for arbitration that cycle, because the requester drops REQ next cycle. The other port may issue in the same cycle (back-to-back, no bubble). Otherwise return to IDLE.
- Requesters must hold REQ and all request fields stable from assertion through the DONE cycle. If REQ drops early, the arbiter still completes the transaction and pulses DONE.
- At most one transaction outstanding; F_DONE and D_DONE are never high together.

Test Plan:
- Reset: assert RESET mid-WAIT_D with MEM_LAT=2 -> all outputs 0 immediately, no D_DONE after release, next F_REQ served normally.
- Lone fetch, MEM_LAT=1: F_REQ, F_ADDR=0x100 at cycle 0 -> M_RD=1, M_ADDR=0x100, M_SIZE=2 at cycle 0; F_DONE and F_RDATA=M_RDATA (0x00A00093) at cycle 1; F_RDATA still 0x00A00093 at cycle 5.
- Store: D_REQ, D_WE=1, D_ADDR=0x11000000, D_WDATA=0x55 with MEM_LAT=3 -> M_WR pulse with those values at cycle 0; D_DONE at cycle 1; D_RDATA unchanged.
- Contention, MEM_LAT=1: both request at cycle 0 -> D issued at cycle 0; D_DONE and F issued at cycle 1; F_DONE at cycle 2.
- Starvation, STARVE_LIMIT=4: F_REQ held while D re-requests continuously -> D wins 4 grants, F wins the 5th, counter returns to 0, D wins the next.
- Latency sweep: MEM_LAT=1..4 loads -> DONE exactly MEM_LAT cycles after issue, BUSY high in between.

Source files
------------

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares one memory port between fetch and load/store with data priority and a fetch starvation guard
module otter_mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        F_REQ,
  input  logic [31:0] F_ADDR,
  output logic        F_DONE,
  output logic [31:0] F_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [1:0]  D_SIZE,
  input  logic        D_SIGN,
  output logic        D_DONE,
  output logic [31:0] D_RDATA,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic        M_RD,
  output logic        M_WR,
  output logic [1:0]  M_SIZE,
  output logic        M_SIGN,
  input  logic [31:0] M_RDATA,
  output logic        BUSY
);
  typedef enum logic [1:0] {IDLE, WAIT_F, WAIT_D} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] starve, starve_n;
  logic wr, wr_n, done, f_req_m, d_req_m, issue_ok, f_win, d_win;
  logic [31:0] f_hold, d_hold;
  // The completing port is masked so the other requester can issue in the same cycle.
  always_comb begin
    done = state != IDLE && cnt == 3'd0;
    F_DONE = done && state == WAIT_F;
    D_DONE = done && state == WAIT_D;
    f_req_m = F_REQ & ~F_DONE;
    d_req_m = D_REQ & ~D_DONE;
    issue_ok = ~RESET & (state == IDLE | done);
    f_win = issue_ok & f_req_m & (~d_req_m | starve == 4'(STARVE_LIMIT));
    d_win = issue_ok & d_req_m & ~f_win;
    M_RD = f_win | (d_win & ~D_WE);
    M_WR = d_win & D_WE;
    M_ADDR = f_win ? F_ADDR : d_win ? D_ADDR : 32'd0;
    M_WDATA = d_win ? D_WDATA : 32'd0;
    M_SIZE = f_win ? 2'b10 : d_win ? D_SIZE : 2'b00;
    M_SIGN = d_win & D_SIGN;
    F_RDATA = F_DONE ? M_RDATA : f_hold;
    D_RDATA = (D_DONE & ~wr) ? M_RDATA : d_hold;
    BUSY = state != IDLE;
    state_n = f_win ? WAIT_F : d_win ? WAIT_D : done ? IDLE : state;
    cnt_n = M_WR ? 3'd0 : M_RD ? 3'(MEM_LAT - 1) : cnt - 3'(cnt != 3'd0);
    wr_n = (f_win | d_win) ? M_WR : wr;
    starve_n = f_win ? 4'd0 : (d_win & f_req_m & starve != 4'(STARVE_LIMIT)) ? starve + 4'd1 : starve;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= 3'd0;
      wr <= 1'b0;
      starve <= 4'd0;
      f_hold <= 32'd0;
      d_hold <= 32'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wr <= wr_n;
      starve <= starve_n;
      if (F_DONE) f_hold <= M_RDATA;
      if (D_DONE & ~wr) d_hold <= M_RDATA;
    end
  end
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb_otter_mem_arbiter: scoreboard bench over four arbiters with MEM_LAT 1..4
module tb_otter_mem_arbiter;
  localparam logic [31:0] K = 32'h00A00193;
  logic CLK = 0, RESET = 1;
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  int checks = 0, failures = 0;
  typedef struct {int i; int k; int c; logic [31:0] a; logic [31:0] b;} ev_t;
  ev_t q[$];
  logic f_req[4], d_req[4], d_we[4], d_sign[4];
  logic [31:0] f_addr[4], d_addr[4], d_wdata[4];
  logic [1:0] d_size[4];
  wire f_done[4], d_done[4], m_rd[4], m_wr[4], m_sign[4], busy[4];
  wire [31:0] f_rdata[4], d_rdata[4], m_addr[4], m_wdata[4], m_rdata[4];
  wire [1:0] m_size[4];
  for (genvar g = 0; g < 4; g++) begin : gi
    int mc = 0;
    logic [31:0] ma = '0;
    otter_mem_arbiter #(.MEM_LAT(g + 1), .STARVE_LIMIT(4)) u (
      .CLK(CLK), .RESET(RESET),
      .F_REQ(f_req[g]), .F_ADDR(f_addr[g]), .F_DONE(f_done[g]), .F_RDATA(f_rdata[g]),
      .D_REQ(d_req[g]), .D_WE(d_we[g]), .D_ADDR(d_addr[g]), .D_WDATA(d_wdata[g]),
      .D_SIZE(d_size[g]), .D_SIGN(d_sign[g]), .D_DONE(d_done[g]), .D_RDATA(d_rdata[g]),
      .M_ADDR(m_addr[g]), .M_WDATA(m_wdata[g]), .M_RD(m_rd[g]), .M_WR(m_wr[g]),
      .M_SIZE(m_size[g]), .M_SIGN(m_sign[g]), .M_RDATA(m_rdata[g]), .BUSY(busy[g]));
    // memory returns addr^K only in the exact cycle MEM_LAT after the read strobe
    always @(posedge CLK) begin
      if (m_rd[g]) begin
        mc <= g + 1;
        ma <= m_addr[g];
      end else if (mc != 0) mc <= mc - 1;
    end
    assign m_rdata[g] = (mc == 1) ? (ma ^ K) : 32'hBAD0BAD0;
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic push(int i, int k, int c, logic [31:0] a, logic [31:0] b);
    ev_t e;
    e.i = i; e.k = k; e.c = c; e.a = a; e.b = b;
    q.push_back(e);
  endtask
  task automatic obs(int i, int k, logic [31:0] a, logic [31:0] b);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event inst=%0d kind=%0d cyc=%0d a=%h b=%h", i, k, cyc, a, b);
    end else begin
      e = q.pop_front();
      if (e.i != i || e.k != k || e.c != cyc || e.a !== a || e.b !== b) begin
        failures++;
        $display("FAIL event got inst=%0d kind=%0d cyc=%0d a=%h b=%h exp inst=%0d kind=%0d cyc=%0d a=%h b=%h",
                 i, k, cyc, a, b, e.i, e.k, e.c, e.a, e.b);
      end
    end
  endtask
  // kinds: 0 F_DONE, 1 D_DONE, 2 read issue, 3 write issue
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (f_done[i] | d_done[i]) chk("done_excl", {31'b0, f_done[i] & d_done[i]}, 32'd0);
      if (f_done[i]) obs(i, 0, f_rdata[i], 32'd0);
      if (d_done[i]) obs(i, 1, d_rdata[i], 32'd0);
      if (m_rd[i]) obs(i, 2, m_addr[i], {29'b0, m_sign[i], m_size[i]});
      if (m_wr[i]) obs(i, 3, m_addr[i], m_wdata[i]);
    end
  end
  task automatic wait_done(int i, bit isf);
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge CLK);
      got = isf ? f_done[i] : d_done[i];
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL timeout inst=%0d fetch=%0d got=no_done exp=done", i, isf);
    end
    tick;
    if (isf) f_req[i] = 0;
    else d_req[i] = 0;
  endtask
  task automatic starve_d(logic [31:0] a);
    int c;
    tick;
    c = cyc;
    d_req[0] = 1; d_addr[0] = a; f_req[0] = 1; f_addr[0] = 32'h500;
    push(0, 2, c, a, 32'd2);
    push(0, 1, c + 1, a ^ K, 32'd0);
    tick;
    f_req[0] = 0;
    tick;
    d_req[0] = 0;
  endtask
  initial begin
    int c;
    for (int i = 0; i < 4; i++) begin
      f_req[i] = 0; d_req[i] = 0; d_we[i] = 0; d_sign[i] = 0;
      f_addr[i] = 0; d_addr[i] = 0; d_wdata[i] = 0; d_size[i] = 2'b10;
    end
    repeat (3) tick;
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", {31'b0, busy[i]}, 32'd0);
      chk("rst_f_rdata", f_rdata[i], 32'd0);
      chk("rst_d_rdata", d_rdata[i], 32'd0);
      chk("rst_m_addr", m_addr[i], 32'd0);
    end
    RESET = 0;
    tick;
    // reset mid WAIT_D on MEM_LAT=2
    c = cyc;
    d_req[1] = 1; d_addr[1] = 32'h200; d_size[1] = 2'b01; d_sign[1] = 1;
    push(1, 2, c, 32'h200, 32'd5);
    tick;
    chk("a_busy", {31'b0, busy[1]}, 32'd1);
    RESET = 1;
    d_req[1] = 0;
    #1;
    chk("a_rst_busy", {31'b0, busy[1]}, 32'd0);
    chk("a_rst_m_rd", {31'b0, m_rd[1]}, 32'd0);
    chk("a_rst_m_addr", m_addr[1], 32'd0);
    chk("a_rst_d_done", {31'b0, d_done[1]}, 32'd0);
    tick; tick;
    RESET = 0;
    repeat (4) tick;
    c = cyc;
    f_req[1] = 1; f_addr[1] = 32'h300;
    push(1, 2, c, 32'h300, 32'd2);
    push(1, 0, c + 2, 32'h300 ^ K, 32'd0);
    wait_done(1, 1);
    // lone fetch, MEM_LAT=1
    tick;
    c = cyc;
    f_req[0] = 1; f_addr[0] = 32'h100;
    push(0, 2, c, 32'h100, 32'd2);
    push(0, 0, c + 1, 32'h00A00093, 32'd0);
    wait_done(0, 1);
    while (cyc < c + 5) tick;
    chk("b_f_hold", f_rdata[0], 32'h00A00093);
    // load then store, MEM_LAT=3
    tick;
    c = cyc;
    d_req[2] = 1; d_we[2] = 0; d_addr[2] = 32'h40; d_size[2] = 2'b10; d_sign[2] = 0;
    push(2, 2, c, 32'h40, 32'd2);
    push(2, 1, c + 3, 32'h00A001D3, 32'd0);
    wait_done(2, 0);
    tick;
    c = cyc;
    d_req[2] = 1; d_we[2] = 1; d_addr[2] = 32'h11000000; d_wdata[2] = 32'h55;
    push(2, 3, c, 32'h11000000, 32'h55);
    push(2, 1, c + 1, 32'h00A001D3, 32'd0);
    wait_done(2, 0);
    d_we[2] = 0;
    tick;
    chk("c_d_hold", d_rdata[2], 32'h00A001D3);
    // contention, MEM_LAT=1
    tick;
    c = cyc;
    f_req[0] = 1; f_addr[0] = 32'h104;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h2000; d_size[0] = 2'b10; d_sign[0] = 0;
    push(0, 2, c, 32'h2000, 32'd2);
    push(0, 1, c + 1, 32'h2000 ^ K, 32'd0);
    push(0, 2, c + 1, 32'h104, 32'd2);
    push(0, 0, c + 2, 32'h104 ^ K, 32'd0);
    fork
      wait_done(0, 0);
      wait_done(0, 1);
    join
    // starvation: four data grants, then fetch forced, then data again
    for (int k = 0; k < 4; k++) starve_d(32'h3000 + 32'(4 * k));
    tick;
    c = cyc;
    d_req[0] = 1; d_addr[0] = 32'h3010; f_req[0] = 1; f_addr[0] = 32'h500;
    push(0, 2, c, 32'h500, 32'd2);
    push(0, 0, c + 1, 32'h500 ^ K, 32'd0);
    push(0, 2, c + 1, 32'h3010, 32'd2);
    push(0, 1, c + 2, 32'h3010 ^ K, 32'd0);
    tick;
    tick;
    f_req[0] = 0;
    tick;
    d_req[0] = 0;
    starve_d(32'h3014);
    // latency sweep
    for (int i = 0; i < 4; i++) begin
      tick;
      c = cyc;
      d_req[i] = 1; d_we[i] = 0; d_addr[i] = 32'h600 + 32'(4 * i); d_size[i] = 2'b10; d_sign[i] = 0;
      push(i, 2, c, 32'h600 + 32'(4 * i), 32'd2);
      push(i, 1, c + i + 1, (32'h600 + 32'(4 * i)) ^ K, 32'd0);
      for (int j = 0; j <= i; j++) begin
        tick;
        chk("f_busy", {31'b0, busy[i]}, 32'd1);
      end
      tick;
      d_req[i] = 0;
      chk("f_idle", {31'b0, busy[i]}, 32'd0);
    end
    repeat (5) tick;
    chk("sb_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
